// File: rtl/comet_ii_state_sequencer_pkg.sv
// Shared types and constants for the COMET II state sequencer.
package comet_ii_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_INIT  = 3'b001,
        S_IFET1 = 3'b010,
        S_IFET2 = 3'b011,
        S_EXEC  = 3'b100,
        S_WBACK = 3'b101
    } state_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LD   = 8'h10;
    localparam logic [7:0] OP_ST   = 8'h11;
    localparam logic [7:0] OP_LAD  = 8'h12;
    localparam logic [7:0] OP_LDR  = 8'h14;
    localparam logic [7:0] OP_PUSH = 8'h70;
    localparam logic [7:0] OP_POP  = 8'h71;
    localparam logic [7:0] OP_CALL = 8'h80;
    localparam logic [7:0] OP_RET  = 8'h81;
    localparam logic [7:0] OP_SVC  = 8'hF0;

endpackage

// File: rtl/comet_ii_state_sequencer_if.sv
// Sequencer-to-datapath/memory signal bundle.
interface comet_ii_state_sequencer_if;
    logic       start;
    logic [7:0] op_code;
    logic       mem_ack;
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       ir_load;
    logic       adr_load;
    logic       adr_en;
    logic       halt;
    logic       bus_err;

    modport master (
        input  start, op_code, mem_ack,
        output state, mem_req, mem_we, ir_load, adr_load, adr_en, halt, bus_err
    );

    modport slave (
        output start, op_code, mem_ack,
        input  state, mem_req, mem_we, ir_load, adr_load, adr_en, halt, bus_err
    );
endinterface

// File: rtl/comet_ii_state_sequencer_op_class.sv
// Combinational opcode classifier: instruction length and EXEC memory access kind.
module comet_ii_op_class
    import comet_ii_pkg::*;
(
    input  logic [7:0] op_code_i,
    output logic       adr_en_o,
    output logic       exec_rd_o,
    output logic       exec_wr_o,
    output logic       is_svc_o
);
    logic [3:0] grp;
    logic       grp_alu;

    assign grp     = op_code_i[7:4];
    assign grp_alu = (grp >= 4'h1) && (grp <= 4'h4);

    always_comb begin
        adr_en_o = 1'b0;
        if ((grp >= 4'h1) && (grp <= 4'h5))
            adr_en_o = ~op_code_i[2];
        else if (grp == 4'h6)
            adr_en_o = 1'b1;
        else if ((op_code_i == OP_PUSH) || (op_code_i == OP_CALL) || (op_code_i == OP_SVC))
            adr_en_o = 1'b1;
    end

    assign exec_wr_o = (op_code_i == OP_ST) || (op_code_i == OP_PUSH) || (op_code_i == OP_CALL);
    // ST is a two-word group-1 op but writes, so it is excluded from the read set.
    assign exec_rd_o = (grp_alu && ~op_code_i[2] && (op_code_i != OP_LAD) && (op_code_i != OP_ST))
                     || (op_code_i == OP_POP) || (op_code_i == OP_RET);
    assign is_svc_o  = (op_code_i == OP_SVC);
endmodule

// File: rtl/comet_ii_state_sequencer.sv
// COMET II fetch/execute state sequencer. Optional bus-wait timeout under
// macro COMET_II_BUS_TIMEOUT_EN.
module comet_ii_state_sequencer
    import comet_ii_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    comet_ii_state_sequencer_if.master bus
);
    state_t state_q, state_d;
    logic   halt_q, halt_d;
    logic   adr_en, exec_rd, exec_wr, is_svc;
    logic   mem_req, mem_we, ir_load, adr_load;
    logic   tmo;

    comet_ii_op_class u_op_class (
        .op_code_i (bus.op_code),
        .adr_en_o  (adr_en),
        .exec_rd_o (exec_rd),
        .exec_wr_o (exec_wr),
        .is_svc_o  (is_svc)
    );

    // Requests decode from registered state so reset drops them without a clock.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IFET1: mem_req = 1'b1;
            S_IFET2: mem_req = adr_en;
            S_EXEC: begin
                mem_req = exec_rd | exec_wr;
                mem_we  = exec_wr;
            end
            default: ;
        endcase
    end

`ifdef COMET_II_BUS_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        bus_err_q, bus_err_d;

    assign tmo_cnt_d = (mem_req && !bus.mem_ack) ? tmo_cnt_q + 16'd1 : 16'd0;
    assign tmo       = mem_req && !bus.mem_ack && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        bus_err_d = bus_err_q;
        if (tmo)
            bus_err_d = 1'b1;
        else if ((state_q == S_IDLE) && bus.start)
            bus_err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 16'd0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign tmo         = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        halt_d   = halt_q;
        ir_load  = 1'b0;
        adr_load = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_INIT;
                halt_d  = 1'b0;
            end
            S_INIT: state_d = S_IFET1;
            S_IFET1: if (bus.mem_ack) begin
                ir_load = 1'b1;
                state_d = S_IFET2;
            end
            S_IFET2: begin
                if (!adr_en) begin
                    state_d = S_EXEC;
                end else if (bus.mem_ack) begin
                    adr_load = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: if (!mem_req || bus.mem_ack) state_d = S_WBACK;
            S_WBACK: begin
                if (is_svc) begin
                    state_d = S_IDLE;
                    halt_d  = 1'b1;
                end else begin
                    state_d = S_IFET1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.mem_req  = mem_req;
    assign bus.mem_we   = mem_we;
    assign bus.ir_load  = ir_load;
    assign bus.adr_load = adr_load;
    assign bus.adr_en   = adr_en;
    assign bus.halt     = halt_q;
endmodule

// File: tb/tb_comet_ii_state_sequencer.sv
// Directed-vector bench for comet_ii_state_sequencer; per-cycle vectors are
// {mem_ack, state[2:0], mem_req, mem_we, ir_load, adr_load}.
module tb_comet_ii_state_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   nchk = 0;
    int   nerr = 0;

    comet_ii_state_sequencer_if bus ();

    comet_ii_state_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mem_ack = 1'b0;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [7:0] op);
        bus.op_code = op;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2;
        nchk++;
        if ({bus.state, bus.mem_req, bus.mem_we, bus.ir_load, bus.adr_load, bus.halt, bus.bus_err} !== 9'b0) begin
            nerr++;
            $display("FAIL reset got=%b exp=%b", {bus.state, bus.mem_req, bus.mem_we, bus.ir_load,
                     bus.adr_load, bus.halt, bus.bus_err}, 9'b0);
        end
    endtask

    task automatic test_adr_en();
        logic [8:0] t [14] = '{9'h110, 9'h014, 9'h024, 9'h120, 9'h152, 9'h056, 9'h164,
                               9'h170, 9'h071, 9'h180, 9'h081, 9'h1F0, 9'h000, 9'h0FF};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus.op_code = t[i][7:0];
            #1;
            nchk++;
            if (bus.adr_en !== t[i][8]) begin
                nerr++;
                $display("FAIL adr_en op=%h got=%b exp=%b", t[i][7:0], bus.adr_en, t[i][8]);
            end
        end
        tick();
    endtask

    task automatic test_ld_rr();
        logic [7:0] v [5] = '{8'b1_010_1010, 8'b0_011_0000, 8'b0_100_0000, 8'b0_101_0000, 8'b0_010_1000};
        do_reset();
        do_start(8'h14);
        for (int i = 0; i < 5; i++) begin
            bus.mem_ack = v[i][7];
            #1;
            nchk++;
            if ({bus.state, bus.mem_req, bus.mem_we, bus.ir_load, bus.adr_load, bus.adr_en} !== {v[i][6:0], 1'b0}) begin
                nerr++;
                $display("FAIL ld_rr cyc%0d got=%b exp=%b", i, {bus.state, bus.mem_req, bus.mem_we,
                         bus.ir_load, bus.adr_load, bus.adr_en}, {v[i][6:0], 1'b0});
            end
            tick();
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_ld_adr_wait();
        logic [7:0] v [11] = '{8'b0_010_1000, 8'b0_010_1000, 8'b1_010_1010,
                               8'b0_011_1000, 8'b0_011_1000, 8'b1_011_1001,
                               8'b0_100_1000, 8'b0_100_1000, 8'b1_100_1000,
                               8'b0_101_0000, 8'b0_010_1000};
        int adl = 0;
        do_reset();
        do_start(8'h10);
        for (int i = 0; i < 11; i++) begin
            bus.mem_ack = v[i][7];
            #1;
            nchk++;
            if ({bus.state, bus.mem_req, bus.mem_we, bus.ir_load, bus.adr_load} !== v[i][6:0]) begin
                nerr++;
                $display("FAIL ld_adr cyc%0d got=%b exp=%b", i, {bus.state, bus.mem_req, bus.mem_we,
                         bus.ir_load, bus.adr_load}, v[i][6:0]);
            end
            if (bus.adr_load === 1'b1) adl++;
            tick();
        end
        bus.mem_ack = 1'b0;
        nchk++;
        if (adl !== 1) begin
            nerr++;
            $display("FAIL ld_adr_pulses got=%0d exp=1", adl);
        end
    endtask

    task automatic test_exec_kinds();
        logic [7:0] push_v [5] = '{8'b1_010_1010, 8'b1_011_1001, 8'b1_100_1100, 8'b0_101_0000, 8'b0_010_1000};
        logic [7:0] lad_v  [5] = '{8'b1_010_1010, 8'b1_011_1001, 8'b1_100_0000, 8'b0_101_0000, 8'b0_010_1000};
        logic [7:0] pop_v  [5] = '{8'b1_010_1010, 8'b1_011_0000, 8'b1_100_1000, 8'b0_101_0000, 8'b0_010_1000};
        logic [7:0] unk_v  [5] = '{8'b1_010_1010, 8'b1_011_0000, 8'b1_100_0000, 8'b0_101_0000, 8'b0_010_1000};
        logic [7:0] ops [4] = '{8'h70, 8'h12, 8'h71, 8'hFF};
        logic [7:0] v [5];
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: v = push_v;
                1: v = lad_v;
                2: v = pop_v;
                default: v = unk_v;
            endcase
            do_reset();
            do_start(ops[k]);
            for (int i = 0; i < 5; i++) begin
                bus.mem_ack = v[i][7];
                #1;
                nchk++;
                if ({bus.state, bus.mem_req, bus.mem_we, bus.ir_load, bus.adr_load} !== v[i][6:0]) begin
                    nerr++;
                    $display("FAIL exec op=%h cyc%0d got=%b exp=%b", ops[k], i, {bus.state, bus.mem_req,
                             bus.mem_we, bus.ir_load, bus.adr_load}, v[i][6:0]);
                end
                tick();
            end
            bus.mem_ack = 1'b0;
        end
    endtask

    task automatic test_svc_halt();
        logic [7:0] v [5] = '{8'b1_010_1010, 8'b1_011_1001, 8'b0_100_0000, 8'b0_101_0000, 8'b0_000_0000};
        do_reset();
        do_start(8'hF0);
        for (int i = 0; i < 5; i++) begin
            bus.mem_ack = v[i][7];
            #1;
            nchk++;
            if ({bus.state, bus.mem_req, bus.mem_we, bus.ir_load, bus.adr_load} !== v[i][6:0]) begin
                nerr++;
                $display("FAIL svc cyc%0d got=%b exp=%b", i, {bus.state, bus.mem_req, bus.mem_we,
                         bus.ir_load, bus.adr_load}, v[i][6:0]);
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        nchk++;
        if ({bus.state, bus.halt} !== 4'b000_1) begin
            nerr++;
            $display("FAIL svc_halt got=%b exp=%b", {bus.state, bus.halt}, 4'b000_1);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nchk++;
        if ({bus.state, bus.halt} !== 4'b001_0) begin
            nerr++;
            $display("FAIL svc_restart got=%b exp=%b", {bus.state, bus.halt}, 4'b001_0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        do_start(8'h14);
        bus.mem_ack = 1'b0;
`ifdef COMET_II_BUS_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            nchk++;
            if ({bus.state, bus.mem_req, bus.bus_err} !== 5'b010_1_0) begin
                nerr++;
                $display("FAIL tmo_wait cyc%0d got=%b exp=%b", i, {bus.state, bus.mem_req, bus.bus_err}, 5'b010_1_0);
            end
            tick();
        end
        nchk++;
        if ({bus.state, bus.mem_req, bus.bus_err} !== 5'b000_0_1) begin
            nerr++;
            $display("FAIL tmo_fire got=%b exp=%b", {bus.state, bus.mem_req, bus.bus_err}, 5'b000_0_1);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nchk++;
        if ({bus.state, bus.bus_err} !== 4'b001_0) begin
            nerr++;
            $display("FAIL tmo_clear got=%b exp=%b", {bus.state, bus.bus_err}, 4'b001_0);
        end
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            nchk++;
            if ({bus.state, bus.mem_req, bus.bus_err} !== 5'b010_1_0) begin
                nerr++;
                $display("FAIL no_tmo cyc%0d got=%b exp=%b", i, {bus.state, bus.mem_req, bus.bus_err}, 5'b010_1_0);
            end
            tick();
        end
`endif
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        do_start(8'h70);
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        #1;
        nchk++;
        if ({bus.state, bus.mem_req, bus.mem_we} !== 5'b100_1_1) begin
            nerr++;
            $display("FAIL rst_pre got=%b exp=%b", {bus.state, bus.mem_req, bus.mem_we}, 5'b100_1_1);
        end
        #2;
        rst = 1'b1;
        #1;
        nchk++;
        if ({bus.state, bus.mem_req, bus.mem_we} !== 5'b000_0_0) begin
            nerr++;
            $display("FAIL rst_async got=%b exp=%b", {bus.state, bus.mem_req, bus.mem_we}, 5'b000_0_0);
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op_code = 8'h00;
        bus.mem_ack = 1'b0;
        test_reset();
        test_adr_en();
        test_ld_rr();
        test_ld_adr_wait();
        test_exec_kinds();
        test_svc_halt();
        test_timeout();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
